// File: rtl/module_result_display_pkg.sv
// Shared types, segment/anode constants and the double-dabble nibble adjust.
package pkg_display;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned BCD_W   = 12;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 4;
  localparam int unsigned CNT_W   = 4;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low anode selects
  localparam logic [AN_W-1:0] AN_UNITS    = 4'b1110;
  localparam logic [AN_W-1:0] AN_TENS     = 4'b1101;
  localparam logic [AN_W-1:0] AN_HUNDREDS = 4'b1011;
  localparam logic [AN_W-1:0] AN_OFF      = 4'b1111;

  // Add 3 to every BCD nibble that is 5 or more, ahead of a shift
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/module_result_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low {g..a} segment decoder.
module module_bcd_to_7seg
  import pkg_display::*;
(
  input  logic [DIGIT_W-1:0] digit_pi,
  output logic [SEG_W-1:0]   seg_po
);

  // Digit lookup; codes above 9 show nothing
  always_comb begin
    seg_po = SEG_BLANK;
    case (digit_pi)
      4'd0:    seg_po = SEG_0;
      4'd1:    seg_po = SEG_1;
      4'd2:    seg_po = SEG_2;
      4'd3:    seg_po = SEG_3;
      4'd4:    seg_po = SEG_4;
      4'd5:    seg_po = SEG_5;
      4'd6:    seg_po = SEG_6;
      4'd7:    seg_po = SEG_7;
      4'd8:    seg_po = SEG_8;
      4'd9:    seg_po = SEG_9;
      default: seg_po = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/module_result_display.sv
// Adder result to 3-digit BCD (sequential double dabble) and multiplexed 7-seg drive.
module module_result_display
  import pkg_display::*;
#(
  parameter int unsigned WIDTH         = 9,
  parameter int unsigned REFRESH_COUNT = 100000
) (
  input  logic               clk_pi,
  input  logic               rst_pi,
  input  logic [WIDTH-1:0]   result_pi,
  input  logic               load_pi,
  output logic               busy_po,
  output logic [BCD_W-1:0]   bcd_po,
  output logic [AN_W-1:0]    an_po,
  output logic [SEG_W-1:0]   seg_po,
  output logic               dp_po
);

  localparam int unsigned REF_W = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;

  state_t                   state;
  logic [WIDTH-1:0]         bin_q;
  logic [BCD_W-1:0]         scratch_q;
  logic [CNT_W-1:0]         iter_q;
  logic [BCD_W+WIDTH-1:0]   shifted_c;

  logic [REF_W-1:0]         ref_q;
  logic [1:0]               idx_q;

  logic [DIGIT_W-1:0]       digit_c;
  logic                     blank_c;
  logic [SEG_W-1:0]         seg_dec_c;

  // One double-dabble step: adjust the BCD nibbles, then shift the whole chain left
  assign shifted_c = {dabble_adjust(scratch_q), bin_q} << 1;

  // Conversion FSM; bcd_po only updates once a full conversion is complete
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      state     <= IDLE;
      busy_po   <= 1'b0;
      bcd_po    <= '0;
      bin_q     <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_pi) begin
            bin_q     <= result_pi;
            scratch_q <= '0;
            iter_q    <= CNT_W'(WIDTH);
            state     <= SHIFT;
            busy_po   <= 1'b1;
          end
        end
        SHIFT: begin
          {scratch_q, bin_q} <= shifted_c;
          iter_q             <= iter_q - CNT_W'(1);
          if (iter_q == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_po  <= scratch_q;
          state   <= IDLE;
          busy_po <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_po <= 1'b0;
        end
      endcase
    end
  end

  // Refresh timer; each wrap moves the scan to the next digit position
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      ref_q <= '0;
      idx_q <= 2'd0;
    end else if (ref_q == REF_W'(REFRESH_COUNT - 1)) begin
      ref_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      ref_q <= ref_q + REF_W'(1);
    end
  end

  // Digit select with leading-zero blanking; position 3 is never lit
  always_comb begin
    an_po   = AN_OFF;
    digit_c = '0;
    blank_c = 1'b1;
    case (idx_q)
      2'd0: begin
        an_po   = AN_UNITS;
        digit_c = bcd_po[3:0];
        blank_c = 1'b0;
      end
      2'd1: begin
        an_po   = AN_TENS;
        digit_c = bcd_po[7:4];
        blank_c = (bcd_po[11:8] == 4'd0) && (bcd_po[7:4] == 4'd0);
      end
      2'd2: begin
        an_po   = AN_HUNDREDS;
        digit_c = bcd_po[11:8];
        blank_c = (bcd_po[11:8] == 4'd0);
      end
      default: begin
        an_po   = AN_OFF;
        digit_c = '0;
        blank_c = 1'b1;
      end
    endcase
  end

  module_bcd_to_7seg u_dec (
    .digit_pi (digit_c),
    .seg_po   (seg_dec_c)
  );

  assign seg_po = blank_c ? SEG_BLANK : seg_dec_c;
  assign dp_po  = 1'b1;

endmodule

// File: tb/tb_module_result_display.sv
// Bench for module_result_display: decimal-arithmetic model plus directed checks.
module tb_module_result_display;

  localparam int unsigned W   = 9;
  localparam int unsigned REF = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  result;
  logic          load;
  logic          busy;
  logic [11:0]   bcd;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  module_result_display #(.WIDTH(W), .REFRESH_COUNT(REF)) dut (
    .clk_pi    (clk),
    .rst_pi    (rst),
    .result_pi (result),
    .load_pi   (load),
    .busy_po   (busy),
    .bcd_po    (bcd),
    .an_po     (an),
    .seg_po    (seg),
    .dp_po     (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Model: a conversion takes W+1 cycles, then the shown value is the decimal of the capture
  int m_rem;
  int m_val;
  int m_shown;
  int m_cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem   <= 0;
      m_val   <= 0;
      m_shown <= 0;
      m_cyc   <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_rem == 0) begin
        if (load) begin
          m_val <= int'(result);
          m_rem <= W + 1;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_shown <= m_val;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int h, t, u, pos;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      h   = m_shown / 100;
      t   = (m_shown / 10) % 10;
      u   = m_shown % 10;
      pos = (m_cyc / REF) % 4;
      case (pos)
        0: begin e_an = 4'b1110; e_seg = seg_of(u); end
        1: begin e_an = 4'b1101; e_seg = (h == 0 && t == 0) ? 7'b1111111 : seg_of(t); end
        2: begin e_an = 4'b1011; e_seg = (h == 0) ? 7'b1111111 : seg_of(h); end
        default: begin e_an = 4'b1111; e_seg = 7'b1111111; end
      endcase
      chk("model_busy", 32'(busy), 32'(m_rem != 0));
      chk("model_bcd", 32'(bcd), 32'({4'(h), 4'(t), 4'(u)}));
      chk("model_an", 32'(an), 32'(e_an));
      chk("model_seg", 32'(seg), 32'(e_seg));
      chk("model_dp", 32'(dp), 32'(1));
    end
  end

  // Load a value, optionally poke a second load mid-conversion, and time busy
  task automatic run_load(input logic [W-1:0] v, input bit inject, input logic [11:0] exp_bcd,
                          input string name);
    int cnt;
    @(negedge clk);
    result = v;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt  = 0;
    while (busy && cnt < 50) begin
      cnt++;
      if (inject && cnt == 3) begin
        result = 9'd7;
        load   = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    chk({name, "_busy_cycles"}, 32'(cnt), 32'd10);
    chk({name, "_bcd"}, 32'(bcd), 32'(exp_bcd));
  endtask

  task automatic wait_an(input logic [3:0] pat, input string name);
    int n;
    n = 0;
    while (an !== pat && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (an !== pat) chk({name, "_timeout"}, 32'(an), 32'(pat));
  endtask

  initial begin
    rst    = 1'b0;
    load   = 1'b0;
    result = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h000);
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b1000000);
    chk("rst_dp", 32'(dp), 32'd1);

    run_load(9'd255, 0, 12'h255, "load255");
    run_load(9'd510, 0, 12'h510, "load510");
    run_load(9'd0,   0, 12'h000, "load0");
    run_load(9'd300, 1, 12'h300, "load300_ignore7");

    // Scan sequence for 45
    run_load(9'd45, 0, 12'h045, "load45");
    wait_an(4'b1111, "s45_a");
    wait_an(4'b1110, "s45_b");
    chk("s45_u_an", 32'(an), 32'b1110);
    chk("s45_u_seg", 32'(seg), 32'b0010010);
    repeat (4) @(negedge clk);
    chk("s45_t_an", 32'(an), 32'b1101);
    chk("s45_t_seg", 32'(seg), 32'b0011001);
    repeat (4) @(negedge clk);
    chk("s45_h_an", 32'(an), 32'b1011);
    chk("s45_h_seg", 32'(seg), 32'b1111111);
    repeat (4) @(negedge clk);
    chk("s45_off_an", 32'(an), 32'b1111);
    repeat (4) @(negedge clk);
    chk("s45_wrap_an", 32'(an), 32'b1110);

    // Inner zero is shown for 105
    run_load(9'd105, 0, 12'h105, "load105");
    wait_an(4'b1101, "s105");
    chk("s105_tens_seg", 32'(seg), 32'b1000000);
    wait_an(4'b1011, "s105h");
    chk("s105_hund_seg", 32'(seg), 32'b1111001);

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    result = 9'd511;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_bcd", 32'(bcd), 32'h000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_load(9'd511, 0, 12'h511, "load511_after_rst");

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/module_result_display.md
# module_result_display

Downstream consumer of the 8-bit carry-lookahead adder. Takes the adder's 9-bit `result_po` on a load strobe and converts it to three BCD digits with a sequential double-dabble engine. It then drives a 4-digit, common-anode 7-segment display by time-multiplexing the digits. Sits between the adder and the board pins in the top level.

## Interface

Parameters:
- `WIDTH`, default 9. Binary input width. Legal range 1..9; the result must fit in three BCD digits (max 511).
- `REFRESH_COUNT`, default 100000. Clock cycles each digit stays active (1 ms at 100 MHz). Must be ≥ 2.

Ports:
- `clk_pi` input 1: the single clock. All state changes on its rising edge.
- `rst_pi` input 1: reset, asynchronous, active-high.
- `result_pi` input `WIDTH`: binary value from the adder.
- `load_pi` input 1: capture strobe. Sampled on `clk_pi`.
- `busy_po` output 1: high while a conversion is in progress.
- `bcd_po` output 12: last completed conversion, `{hundreds, tens, units}`.
- `an_po` output 4: digit anodes, active-low.
- `seg_po` output 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp_po` output 1: decimal point, active-low. Held at 1 (off).

## Operation

- FSM states: `IDLE`, `SHIFT`, `DONE`. `busy_po = (state != IDLE)`.
- **IDLE**: when `load_pi` = 1, do all of the following, then go to `SHIFT`:
  - capture `result_pi` into the binary shift register;
  - clear the 12-bit scratch BCD register;
  - set the iteration counter to `WIDTH`.
- **SHIFT**: each cycle, do the following:
  - add 3 to every scratch nibble that is ≥ 5;
  - shift `{scratch, binary}` left by 1;
  - decrement the counter.
  - After the `WIDTH`-th shift, go to `DONE`.
- **DONE**: copy scratch into `bcd_po`, then go to `IDLE`.
- `load_pi` is ignored in `SHIFT` and `DONE`. There is no queuing.
- `bcd_po` keeps the old value until `DONE`, so the display never shows partial results.
- **Scan**: the refresh counter counts 0..`REFRESH_COUNT`-1 and wraps. On each wrap, the digit index advances 0→1→2→3→0.
  - Index 0: units, `an_po` = 1110.
  - Index 1: tens, `an_po` = 1101.
  - Index 2: hundreds, `an_po` = 1011.
  - Index 3: unused, `an_po` = 1111.
- Leading-zero blanking, where blank means `seg_po` = 1111111:
  - hundreds is blank when it is 0;
  - tens is blank when hundreds and tens are both 0;
  - units is always shown.
- Scanning runs independently of conversion.

## Timing

- Reset values (asynchronous, immediate):
  - state `IDLE`, `busy_po` 0, `bcd_po` 12'h000;
  - refresh counter 0, digit index 0;
  - `an_po` 1110, `seg_po` 1000000 ('0'), `dp_po` 1.
- Latency: `load_pi` sampled at edge N, then:
  - `busy_po` is high from edge N through edge N+`WIDTH`+1, which is `WIDTH`+1 cycles (10 for the default);
  - the new `bcd_po` is valid after edge N+`WIDTH`+1.
- The earliest accepted next load is at edge N+`WIDTH`+2.
- `an_po` and `seg_po` are combinational from the digit index and `bcd_po`. They change only after clock edges.
- If reset asserts mid-conversion, the partial result is discarded, `busy_po` drops immediately, and `bcd_po` returns to 000.
- When `load_pi` and a refresh wrap occur in the same cycle, both take effect independently.

## Structure

- Package `pkg_display` holds the following:
  - `typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE}`;
  - 7-segment constants `SEG_0`..`SEG_9` and `SEG_BLANK`;
  - the anode pattern constants.
- Sub-module `module_bcd_to_7seg`: a combinational 4-bit BCD to active-low `{g..a}` decoder. Instantiated once after the digit mux.

## Test plan

- Reset with no load: `busy_po` 0, `bcd_po` 000, `an_po` 1110, `seg_po` 1000000, `dp_po` 1.
- Load `result_pi`=255: `busy_po` high exactly 10 cycles, then `bcd_po`=12'h255. Load 510 → 12'h510. Load 0 → 12'h000.
- Load 300, then pulse `load_pi` with 7 at the 3rd busy cycle: second load ignored, `bcd_po`=12'h300, `busy_po` total 10 cycles.
- `REFRESH_COUNT`=4, load 45: repeating sequence, each step 4 cycles:
  - `an_po` 1110 / `seg_po` 0010010 ('5');
  - `an_po` 1101 / `seg_po` 0011001 ('4');
  - `an_po` 1011 / `seg_po` 1111111;
  - `an_po` 1111.
- Load 105 with `REFRESH_COUNT`=4: tens digit shows '0' (1000000), not blank.
- Load 511 and assert `rst_pi` mid-shift, asynchronously between edges:
  - `busy_po` and `bcd_po` go to 0 without waiting for a clock edge;
  - after release, a new load of 511 gives 12'h511.
